// File: rtl/framebuffer_scanout.sv
// Framebuffer read master: scans the RAM in raster order, absorbs its 1-cycle read latency
// through a 2-entry skid FIFO and presents pixels with x/y and line/frame markers.
module framebuffer_scanout #(
  parameter  int FB_WIDTH   = 160,
  parameter  int FB_HEIGHT  = 120,
  parameter  int DATA_WIDTH = 12,
  localparam int FB_SIZE    = FB_WIDTH * FB_HEIGHT,
  localparam int ADDR_WIDTH = $clog2(FB_SIZE),
  localparam int XW         = $clog2(FB_WIDTH),
  localparam int YW         = $clog2(FB_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  fb_clearing,
  output logic [ADDR_WIDTH-1:0] fb_addr_read,
  input  logic [DATA_WIDTH-1:0] fb_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [XW-1:0]         m_x,
  output logic [YW-1:0]         m_y,
  output logic                  m_eol,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_CLR = 2'd1;
  localparam logic [1:0] S_SCAN     = 2'd2;
  localparam logic [1:0] S_DRAIN    = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_SIZE - 1);
  localparam logic [XW-1:0]         LAST_X    = XW'(FB_WIDTH - 1);
  localparam logic [YW-1:0]         LAST_Y    = YW'(FB_HEIGHT - 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic                  vld_p1;
  logic [1:0]            occ;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic [XW-1:0]         x_cnt;
  logic [YW-1:0]         y_cnt;
  logic                  done_r;

  logic       pop;
  logic [2:0] level;
  logic       issue;
  logic       at_last;
  logic       last_pop;

  // Outstanding = buffered + in flight, counted after this cycle's pop, so the FIFO never overflows.
  assign pop      = m_valid & m_ready;
  assign level    = {1'b0, occ} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue    = (state == S_SCAN) && (level < 3'd2);
  assign at_last  = (x_cnt == LAST_X) && (y_cnt == LAST_Y);
  assign last_pop = pop & at_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE:     if (start) state <= fb_clearing ? S_WAIT_CLR : S_SCAN;
        S_WAIT_CLR: if (!fb_clearing) state <= S_SCAN;
        S_SCAN:     if (issue && (addr_p0 == LAST_ADDR)) state <= S_DRAIN;
        S_DRAIN: begin
          if (last_pop) begin
            state  <= S_IDLE;
            done_r <= 1'b1;
          end
        end
        default:    state <= S_IDLE;
      endcase
    end
  end

  // Stage p0: address issue; the counter parks on the last address until the frame ends.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_p0 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= issue;
      if (issue && (addr_p0 != LAST_ADDR))
        addr_p0 <= addr_p0 + ADDR_WIDTH'(1);
      else if (last_pop)
        addr_p0 <= '0;
    end
  end

  // Stage p1: RAM data lands in the FIFO one cycle after its address was issued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ    <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      occ <= occ + {1'b0, vld_p1} - {1'b0, pop};
      if (vld_p1) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1) fifo_mem[wr_ptr] <= fb_data;
  end

  // Stage p2: output-side coordinates follow accepted beats, not issued addresses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (pop) begin
      if (at_last) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (x_cnt == LAST_X) begin
        x_cnt <= '0;
        y_cnt <= y_cnt + YW'(1);
      end else begin
        x_cnt <= x_cnt + XW'(1);
      end
    end
  end

  assign fb_addr_read = addr_p0;
  assign m_valid      = (occ != 2'd0);
  assign m_data       = m_valid ? fifo_mem[rd_ptr] : '0;
  assign m_x          = x_cnt;
  assign m_y          = y_cnt;
  assign m_eol        = m_valid && (x_cnt == LAST_X);
  assign m_last       = m_valid && at_last;
  assign busy         = (state != S_IDLE);
  assign done         = done_r;

  no_fifo_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !((occ == 2'd2) && vld_p1 && !pop));

endmodule
